// File: rtl/add_sub_reservation_station.sv
// Add/sub reservation station: holds ops until op1/op2/op3 are known (CDB snoop), issues lowest ready entry.
// Issue one cycle after an all-valid dispatch; a stalled issue is locked to its entry until accepted.
package add_sub_pkg;
  typedef struct packed {
    logic is_sub;
    logic add_ca;
    logic set_flags;
  } add_sub_decode_t;
endpackage

module add_sub_reservation_station
  import add_sub_pkg::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int RS_DEPTH    = 4,
  parameter int RS_ID_BASE  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   dispatch_valid,
  output logic                   dispatch_ready,
  input  logic [4:0]             dispatch_reg_addr,
  input  add_sub_decode_t        dispatch_control,
  input  logic                   op1_valid_in,
  input  logic [RS_ID_WIDTH-1:0] op1_tag_in,
  input  logic [31:0]            op1_value_in,
  input  logic                   op2_valid_in,
  input  logic [RS_ID_WIDTH-1:0] op2_tag_in,
  input  logic [31:0]            op2_value_in,
  input  logic                   op3_valid_in,
  input  logic [RS_ID_WIDTH-1:0] op3_tag_in,
  input  logic [31:0]            op3_value_in,
  input  logic                   cdb_valid,
  input  logic [RS_ID_WIDTH-1:0] cdb_tag,
  input  logic [31:0]            cdb_value,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [RS_ID_WIDTH-1:0] issue_rs_id,
  output logic [4:0]             issue_reg_addr,
  output logic [31:0]            issue_op1,
  output logic [31:0]            issue_op2,
  output logic                   issue_carry,
  output add_sub_decode_t        issue_control
);

  localparam int IW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  typedef struct packed {
    logic                        busy;
    logic [4:0]                  reg_addr;
    add_sub_decode_t             control;
    logic [2:0]                  vld;
    logic [2:0][RS_ID_WIDTH-1:0] tag;
    logic [31:0]                 op1;
    logic [31:0]                 op2;
    logic                        carry;
  } entry_t;

  entry_t            ent_q [RS_DEPTH];
  entry_t            ent_d [RS_DEPTH];
  entry_t            new_ent;
  logic              rst_q;
  logic              lock_q;
  logic [IW-1:0]     lock_idx_q;
  logic [IW-1:0]     free_idx;
  logic [IW-1:0]     sel_idx;
  logic              free_found;
  logic              sel_found;
  logic              live;
  logic              dispatch_fire;
  logic              accept;
  logic [RS_DEPTH-1:0] rdy;
  logic [2:0]        fwd;
  logic              unused_op3_hi;

  // Only the carry bit of op3 reaches the unit.
  assign unused_op3_hi = ^op3_value_in[31:1];

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    rdy        = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      rdy[i] = ent_q[i].busy & (&ent_q[i].vld);
      if (!ent_q[i].busy) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      if (rdy[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
    if (lock_q) begin
      sel_found = rdy[lock_idx_q];
      sel_idx   = lock_idx_q;
    end
  end

  // rst_q keeps the station quiet for the first cycle after reset releases.
  assign live           = ~rst & ~rst_q & ~flush;
  assign dispatch_ready = live & free_found;
  assign dispatch_fire  = dispatch_valid & dispatch_ready;
  assign issue_valid    = live & sel_found;
  assign accept         = issue_valid & issue_ready;

  always_comb begin
    fwd[0] = ~op1_valid_in & cdb_valid & (cdb_tag == op1_tag_in);
    fwd[1] = ~op2_valid_in & cdb_valid & (cdb_tag == op2_tag_in);
    fwd[2] = ~op3_valid_in & cdb_valid & (cdb_tag == op3_tag_in);
    new_ent          = '0;
    new_ent.busy     = 1'b1;
    new_ent.reg_addr = dispatch_reg_addr;
    new_ent.control  = dispatch_control;
    new_ent.vld      = {op3_valid_in | fwd[2], op2_valid_in | fwd[1], op1_valid_in | fwd[0]};
    new_ent.tag      = {op3_tag_in, op2_tag_in, op1_tag_in};
    new_ent.op1      = fwd[0] ? cdb_value    : op1_value_in;
    new_ent.op2      = fwd[1] ? cdb_value    : op2_value_in;
    new_ent.carry    = fwd[2] ? cdb_value[0] : op3_value_in[0];
  end

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      for (int k = 0; k < 3; k++) begin
        if (ent_q[i].busy && cdb_valid && !ent_q[i].vld[k] && (ent_q[i].tag[k] == cdb_tag))
          ent_d[i].vld[k] = 1'b1;
      end
      if (ent_d[i].vld[0] && !ent_q[i].vld[0]) ent_d[i].op1   = cdb_value;
      if (ent_d[i].vld[1] && !ent_q[i].vld[1]) ent_d[i].op2   = cdb_value;
      if (ent_d[i].vld[2] && !ent_q[i].vld[2]) ent_d[i].carry = cdb_value[0];
      if (accept && (sel_idx == IW'(i)))        ent_d[i].busy  = 1'b0;
      if (dispatch_fire && (free_idx == IW'(i))) ent_d[i]      = new_ent;
      if (flush)                                 ent_d[i].busy  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= ent_d[i];
      if (flush || accept) begin
        lock_q <= 1'b0;
      end else if (issue_valid) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel_idx;
      end
    end
  end

  always_comb begin
    issue_rs_id    = '0;
    issue_reg_addr = '0;
    issue_op1      = '0;
    issue_op2      = '0;
    issue_carry    = 1'b0;
    issue_control  = '0;
    if (issue_valid) begin
      issue_rs_id    = RS_ID_WIDTH'(RS_ID_BASE + int'(sel_idx));
      issue_reg_addr = ent_q[sel_idx].reg_addr;
      issue_op1      = ent_q[sel_idx].op1;
      issue_op2      = ent_q[sel_idx].op2;
      issue_carry    = ent_q[sel_idx].carry;
      issue_control  = ent_q[sel_idx].control;
    end
  end

endmodule

// File: tb/tb_add_sub_reservation_station.sv
// Directed bench for add_sub_reservation_station: reset, issue, CDB capture, forwarding, lock, flush.
module tb_add_sub_reservation_station;
  import add_sub_pkg::*;

  localparam int W    = 5;
  localparam int D    = 4;
  localparam int BASE = 8;

  logic clk = 1'b0;
  logic rst, flush, dispatch_valid, dispatch_ready;
  logic [4:0] dispatch_reg_addr;
  add_sub_decode_t dispatch_control;
  logic op1_valid_in, op2_valid_in, op3_valid_in;
  logic [W-1:0] op1_tag_in, op2_tag_in, op3_tag_in;
  logic [31:0] op1_value_in, op2_value_in, op3_value_in;
  logic cdb_valid;
  logic [W-1:0] cdb_tag;
  logic [31:0] cdb_value;
  logic issue_valid, issue_ready;
  logic [W-1:0] issue_rs_id;
  logic [4:0] issue_reg_addr;
  logic [31:0] issue_op1, issue_op2;
  logic issue_carry;
  add_sub_decode_t issue_control;

  int compared = 0;
  int mismatches = 0;
  logic [79:0] got, exp;

  add_sub_reservation_station #(.RS_ID_WIDTH(W), .RS_DEPTH(D), .RS_ID_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_reg_addr(dispatch_reg_addr), .dispatch_control(dispatch_control),
    .op1_valid_in(op1_valid_in), .op1_tag_in(op1_tag_in), .op1_value_in(op1_value_in),
    .op2_valid_in(op2_valid_in), .op2_tag_in(op2_tag_in), .op2_value_in(op2_value_in),
    .op3_valid_in(op3_valid_in), .op3_tag_in(op3_tag_in), .op3_value_in(op3_value_in),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rs_id(issue_rs_id),
    .issue_reg_addr(issue_reg_addr), .issue_op1(issue_op1), .issue_op2(issue_op2),
    .issue_carry(issue_carry), .issue_control(issue_control)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic idle;
    flush = 1'b0; dispatch_valid = 1'b0; dispatch_reg_addr = '0; dispatch_control = '0;
    op1_valid_in = 1'b0; op1_tag_in = '0; op1_value_in = '0;
    op2_valid_in = 1'b0; op2_tag_in = '0; op2_value_in = '0;
    op3_valid_in = 1'b0; op3_tag_in = '0; op3_value_in = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
  endtask

  task automatic disp(input logic [4:0] ra, input logic [2:0] c,
                      input logic v1, input logic [W-1:0] t1, input logic [31:0] x1,
                      input logic v2, input logic [W-1:0] t2, input logic [31:0] x2,
                      input logic [31:0] x3);
    dispatch_valid = 1'b1; dispatch_reg_addr = ra; dispatch_control = add_sub_decode_t'(c);
    op1_valid_in = v1; op1_tag_in = t1; op1_value_in = x1;
    op2_valid_in = v2; op2_tag_in = t2; op2_value_in = x2;
    op3_valid_in = 1'b1; op3_tag_in = '0; op3_value_in = x3;
  endtask

  task automatic test_reset;
    rst = 1'b1; idle(); issue_ready = 1'b1;
    disp(5'd1, 3'b001, 1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2, 32'h0);
    tick; sample;
    got = {dispatch_ready, issue_valid, issue_rs_id, issue_reg_addr, issue_op1, issue_op2, issue_carry, issue_control};
    exp = '0; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL reset_outputs got=%h exp=%h", got, exp); end
    tick; rst = 1'b0; idle(); sample;
    got = {dispatch_ready, issue_valid}; exp = {1'b0, 1'b0}; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL reset_first_cycle got=%h exp=%h", got, exp); end
    tick; sample;
    got = {dispatch_ready, issue_valid}; exp = {1'b1, 1'b0}; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL reset_released got=%h exp=%h", got, exp); end
  endtask

  task automatic test_basic;
    tick; disp(5'd3, 3'b001, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd7, 32'd0); issue_ready = 1'b1; sample;
    got = {dispatch_ready, issue_valid}; exp = {1'b1, 1'b0}; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL basic_dispatch got=%h exp=%h", got, exp); end
    tick; idle(); sample;
    got = {issue_valid, issue_rs_id, issue_reg_addr, issue_op1, issue_op2, issue_carry, issue_control};
    exp = {1'b1, 5'd8, 5'd3, 32'd5, 32'd7, 1'b0, 3'b001}; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL basic_issue got=%h exp=%h", got, exp); end
    tick; sample;
    got = {79'd0, issue_valid}; exp = '0; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL basic_drained got=%h exp=%h", got, exp); end
  endtask

  task automatic test_cdb_capture;
    tick; disp(5'd4, 3'b010, 1'b1, 5'd0, 32'd1, 1'b0, 5'd9, 32'd0, 32'd1); sample;
    tick; idle(); cdb_valid = 1'b1; cdb_tag = 5'd10; cdb_value = 32'hDEAD; sample;
    got = {79'd0, issue_valid}; exp = '0; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL cdb_wait got=%h exp=%h", got, exp); end
    tick; cdb_tag = 5'd9; cdb_value = 32'h10; sample;
    got = {79'd0, issue_valid}; exp = '0; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL cdb_capture_cycle got=%h exp=%h", got, exp); end
    tick; idle(); sample;
    got = {issue_valid, issue_rs_id, issue_reg_addr, issue_op1, issue_op2, issue_carry, issue_control};
    exp = {1'b1, 5'd8, 5'd4, 32'd1, 32'h10, 1'b1, 3'b010}; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL cdb_issue got=%h exp=%h", got, exp); end
    tick; sample;
  endtask

  task automatic test_forward;
    tick; disp(5'd5, 3'b100, 1'b0, 5'd6, 32'h1234, 1'b1, 5'd0, 32'd2, 32'd0);
    cdb_valid = 1'b1; cdb_tag = 5'd6; cdb_value = 32'hAB; sample;
    tick; idle(); sample;
    got = {issue_valid, issue_rs_id, issue_reg_addr, issue_op1, issue_op2};
    exp = {1'b1, 5'd8, 5'd5, 32'hAB, 32'd2}; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL forward_issue got=%h exp=%h", got, exp); end
    tick; sample;
  endtask

  task automatic test_back_to_back;
    issue_ready = 1'b1;
    tick; disp(5'd1, 3'b000, 1'b1, 5'd0, 32'h100, 1'b1, 5'd0, 32'd1, 32'd0); sample;
    tick; disp(5'd2, 3'b000, 1'b1, 5'd0, 32'h200, 1'b1, 5'd0, 32'd1, 32'd0); sample;
    got = {issue_valid, issue_rs_id, issue_op1}; exp = {1'b1, 5'd8, 32'h100}; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL b2b_first got=%h exp=%h", got, exp); end
    tick; disp(5'd3, 3'b000, 1'b1, 5'd0, 32'h300, 1'b1, 5'd0, 32'd1, 32'd0); sample;
    got = {issue_valid, issue_rs_id, issue_op1}; exp = {1'b1, 5'd9, 32'h200}; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL b2b_second got=%h exp=%h", got, exp); end
    tick; idle(); sample;
    got = {issue_valid, issue_rs_id, issue_op1}; exp = {1'b1, 5'd8, 32'h300}; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL b2b_third got=%h exp=%h", got, exp); end
    tick; sample;
  endtask

  task automatic test_fill_lock;
    issue_ready = 1'b0;
    tick; disp(5'd10, 3'b000, 1'b0, 5'd20, 32'd0, 1'b1, 5'd0, 32'd0, 32'd0); sample;
    tick; disp(5'd11, 3'b000, 1'b0, 5'd21, 32'd0, 1'b1, 5'd0, 32'd0, 32'd0); sample;
    tick; disp(5'd12, 3'b000, 1'b1, 5'd0, 32'h22, 1'b1, 5'd0, 32'd0, 32'd0); sample;
    got = {dispatch_ready, issue_valid}; exp = {1'b1, 1'b0}; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL fill_third got=%h exp=%h", got, exp); end
    tick; disp(5'd13, 3'b000, 1'b1, 5'd0, 32'h33, 1'b1, 5'd0, 32'd0, 32'd0); sample;
    got = {dispatch_ready, issue_valid, issue_rs_id, issue_op1}; exp = {1'b1, 1'b1, 5'd10, 32'h22}; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL fill_fourth got=%h exp=%h", got, exp); end
    tick; idle(); cdb_valid = 1'b1; cdb_tag = 5'd20; cdb_value = 32'h20; sample;
    got = {dispatch_ready, issue_valid, issue_rs_id}; exp = {1'b0, 1'b1, 5'd10}; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL fill_full got=%h exp=%h", got, exp); end
    tick; idle(); sample;
    got = {issue_valid, issue_rs_id, issue_reg_addr, issue_op1}; exp = {1'b1, 5'd10, 5'd12, 32'h22}; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL lock_hold got=%h exp=%h", got, exp); end
    tick; issue_ready = 1'b1; sample;
    got = {dispatch_ready, issue_valid, issue_rs_id}; exp = {1'b0, 1'b1, 5'd10}; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL lock_accept got=%h exp=%h", got, exp); end
    tick; issue_ready = 1'b0; sample;
    got = {dispatch_ready, issue_valid, issue_rs_id, issue_reg_addr, issue_op1};
    exp = {1'b1, 1'b1, 5'd8, 5'd10, 32'h20}; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL after_accept got=%h exp=%h", got, exp); end
  endtask

  task automatic test_flush;
    tick; disp(5'd14, 3'b000, 1'b1, 5'd0, 32'h44, 1'b1, 5'd0, 32'd0, 32'd0);
    flush = 1'b1; issue_ready = 1'b1; sample;
    got = {dispatch_ready, issue_valid}; exp = {1'b0, 1'b0}; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL flush_outputs got=%h exp=%h", got, exp); end
    tick; idle(); cdb_valid = 1'b1; cdb_tag = 5'd21; cdb_value = 32'h21; sample;
    got = {dispatch_ready, issue_valid}; exp = {1'b1, 1'b0}; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL flush_cleared got=%h exp=%h", got, exp); end
    tick; idle(); issue_ready = 1'b0;
    disp(5'd15, 3'b000, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'd0, 32'd0); sample;
    got = {dispatch_ready, issue_valid}; exp = {1'b1, 1'b0}; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL flush_cdb_noeffect got=%h exp=%h", got, exp); end
    tick; idle(); sample;
    got = {issue_valid, issue_rs_id, issue_reg_addr, issue_op1}; exp = {1'b1, 5'd8, 5'd15, 32'h55}; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL flush_reuse got=%h exp=%h", got, exp); end
  endtask

  task automatic test_reset_mid;
    tick; disp(5'd16, 3'b000, 1'b0, 5'd25, 32'd0, 1'b1, 5'd0, 32'd0, 32'd0); sample;
    tick; idle(); rst = 1'b1; issue_ready = 1'b1; sample;
    got = {dispatch_ready, issue_valid, issue_rs_id, issue_reg_addr, issue_op1, issue_op2, issue_carry, issue_control};
    exp = '0; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL midrst_during got=%h exp=%h", got, exp); end
    tick; rst = 1'b0; cdb_valid = 1'b1; cdb_tag = 5'd25; cdb_value = 32'h1; sample;
    got = {dispatch_ready, issue_valid}; exp = {1'b0, 1'b0}; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL midrst_next got=%h exp=%h", got, exp); end
    tick; idle(); sample;
    got = {dispatch_ready, issue_valid}; exp = {1'b1, 1'b0}; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL midrst_released got=%h exp=%h", got, exp); end
    tick; sample;
    got = {79'd0, issue_valid}; exp = '0; compared++;
    if (got !== exp) begin mismatches++; $display("FAIL midrst_no_old got=%h exp=%h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cdb_capture();
    test_forward();
    test_back_to_back();
    test_fill_lock();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatches);
    $finish;
  end

endmodule
